// File: rtl/br_gshare_pred_pkg.sv
// Shared types and constants for the gshare branch direction predictor.
// The status-word struct is sized for the default history/PHT geometry.
package br_gshare_pred_pkg;

    localparam int PRED_MAX_DEPTH = 8;
    localparam int GHR_LEN_DEF    = 10;
    localparam int PHT_DEPTH_DEF  = 1024;
    localparam logic [1:0] CNT_RST = 2'b01;

    typedef struct packed {
        logic                             pred_taken;
        logic [$clog2(PHT_DEPTH_DEF)-1:0] pht_idx;
        logic [GHR_LEN_DEF-1:0]           ghr;
    } br_status_t;

    function automatic logic [1:0] sat_upd(input logic [1:0] cnt, input logic inc);
        if (inc) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else     return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/br_gshare_pred_pht.sv
// Pattern history table: flop array of 2-bit saturating counters,
// one combinational read port and one read-modify-write update port.
module br_pht
    import br_gshare_pred_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic [ADDR-1:0] rd_idx,
    output logic [1:0]      rd_cnt,
    input  logic            wr_en,
    input  logic [ADDR-1:0] wr_idx,
    input  logic            wr_inc
);

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d [DEPTH];

    // Read sees the pre-update value; no write-to-read bypass.
    assign rd_cnt = cnt_q[rd_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) cnt_d[wr_idx] = sat_upd(cnt_q[wr_idx], wr_inc);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/br_gshare_pred.sv
// Gshare conditional-branch predictor: PC^GHR indexed PHT, one-cycle issue
// stage feeding the status buffer, mispredict restore and commit training.
module br_gshare_pred
    import br_gshare_pred_pkg::*;
#(
    parameter int PC        = 32,
    parameter int GHR_LEN   = GHR_LEN_DEF,
    parameter int PHT_DEPTH = PHT_DEPTH_DEF,
    parameter int SB_DEPTH  = PRED_MAX_DEPTH,
    parameter int STATUS    = 64,
    parameter int PHT_ADDR  = $clog2(PHT_DEPTH),
    parameter int SB_ADDR   = $clog2(SB_DEPTH)
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic               pred_req_,
    input  logic [PC-1:0]      pred_pc,
    output logic               pred_stall,
    output logic               pred_valid_,
    output logic               pred_taken,
    output logic [SB_ADDR-1:0] pred_st_idx,
    output logic               sb_we_,
    output logic [STATUS-1:0]  sb_wd,
    input  logic               sb_busy,
    input  logic               wb_valid_,
    input  logic               wb_taken,
    input  logic [SB_ADDR-1:0] wb_st_idx,
    input  logic [STATUS-1:0]  wb_status,
    output logic               wb_flush_,
    input  logic               com_,
    input  logic               com_taken,
    input  logic [STATUS-1:0]  com_status,
    output logic               sb_re_
);

    localparam int PT_BIT = GHR_LEN + PHT_ADDR;

    logic                ghr_q, ghr_d_unused;
    logic [GHR_LEN-1:0]  ghr_r_q, ghr_r_d, ghr_fwd;
    logic [SB_ADDR-1:0]  alloc_q, alloc_d;
    logic                s1_vld_q, s1_vld_d;
    logic [GHR_LEN-1:0]  s1_ghr_q, s1_ghr_d;
    logic [PHT_ADDR-1:0] s1_idx_q, s1_idx_d;
    logic                s1_taken_q, s1_taken_d;
    logic                mispredict, accept, issue;
    logic [PHT_ADDR-1:0] pht_idx;
    logic [1:0]          pht_cnt;

    assign ghr_q        = 1'b0;
    assign ghr_d_unused = ghr_q;

    function automatic logic [SB_ADDR-1:0] sb_inc(input logic [SB_ADDR-1:0] a);
        return (a == SB_ADDR'(SB_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    assign mispredict = !wb_valid_ && (wb_taken != wb_status[PT_BIT]);
    assign wb_flush_  = !mispredict;
    assign sb_re_     = com_;
    assign pred_stall = sb_busy || mispredict;
    assign accept     = !pred_req_ && !pred_stall;
    assign issue      = s1_vld_q && !mispredict;

    // A back-to-back request must see the history including S1's direction.
    assign ghr_fwd = issue ? {ghr_r_q[GHR_LEN-2:0], s1_taken_q} : ghr_r_q;
    assign pht_idx = pred_pc[PHT_ADDR+1:2] ^ PHT_ADDR'(ghr_fwd);

    br_pht #(.DEPTH(PHT_DEPTH), .ADDR(PHT_ADDR)) u_pht (
        .clk    (clk),
        .reset_ (reset_),
        .rd_idx (pht_idx),
        .rd_cnt (pht_cnt),
        .wr_en  (!com_),
        .wr_idx (com_status[GHR_LEN +: PHT_ADDR]),
        .wr_inc (com_taken)
    );

    always_comb begin
        ghr_r_d    = ghr_r_q;
        alloc_d    = alloc_q;
        s1_vld_d   = accept;
        s1_ghr_d   = s1_ghr_q;
        s1_idx_d   = s1_idx_q;
        s1_taken_d = s1_taken_q;
        if (mispredict) begin
            ghr_r_d = {wb_status[GHR_LEN-2:0], wb_taken};
            alloc_d = sb_inc(wb_st_idx);
        end else if (issue) begin
            ghr_r_d = ghr_fwd;
            alloc_d = sb_inc(alloc_q);
        end
        if (accept) begin
            s1_ghr_d   = ghr_fwd;
            s1_idx_d   = pht_idx;
            s1_taken_d = pht_cnt[1];
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ghr_r_q    <= '0;
            alloc_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_ghr_q   <= '0;
            s1_idx_q   <= '0;
            s1_taken_q <= 1'b0;
        end else begin
            ghr_r_q    <= ghr_r_d;
            alloc_q    <= alloc_d;
            s1_vld_q   <= s1_vld_d;
            s1_ghr_q   <= s1_ghr_d;
            s1_idx_q   <= s1_idx_d;
            s1_taken_q <= s1_taken_d;
        end
    end

    always_comb begin
        pred_valid_ = !issue;
        sb_we_      = !issue;
        pred_taken  = issue && s1_taken_q;
        pred_st_idx = alloc_q;
        sb_wd       = '0;
        if (issue) sb_wd[PT_BIT:0] = {s1_taken_q, s1_idx_q, s1_ghr_q};
    end

endmodule

// File: tb/tb_br_gshare_pred.sv
// Randomized scoreboard bench for br_gshare_pred against a queue/array model.
module tb_br_gshare_pred;
    import br_gshare_pred_pkg::*;

    logic        clk = 0, reset_ = 0;
    logic        pred_req_ = 1, sb_busy = 0, wb_valid_ = 1, wb_taken = 0;
    logic        com_ = 1, com_taken = 0;
    logic [31:0] pred_pc = 0;
    logic [2:0]  wb_st_idx = 0;
    logic [63:0] wb_status = 0, com_status = 0;
    logic        pred_stall, pred_valid_, pred_taken, sb_we_, wb_flush_, sb_re_;
    logic [2:0]  pred_st_idx;
    logic [63:0] sb_wd;

    br_gshare_pred dut (
        .clk(clk), .reset_(reset_), .pred_req_(pred_req_), .pred_pc(pred_pc),
        .pred_stall(pred_stall), .pred_valid_(pred_valid_), .pred_taken(pred_taken),
        .pred_st_idx(pred_st_idx), .sb_we_(sb_we_), .sb_wd(sb_wd), .sb_busy(sb_busy),
        .wb_valid_(wb_valid_), .wb_taken(wb_taken), .wb_st_idx(wb_st_idx),
        .wb_status(wb_status), .wb_flush_(wb_flush_), .com_(com_), .com_taken(com_taken),
        .com_status(com_status), .sb_re_(sb_re_)
    );

    always #5 clk = ~clk;

    typedef struct { bit taken; int st; logic [63:0] wd; } exp_t;
    exp_t q[$];
    int   recent[$];
    int   m_pht[1024];
    int   m_ghr, m_alloc;
    bit   prev_acc;
    int   tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_pht[i] = 1;
        m_ghr = 0; m_alloc = 0; prev_acc = 0;
        q.delete(); recent.delete();
    endtask

    function automatic logic [63:0] mk_status(input int ghr, input int idx, input bit tk);
        logic [63:0] w;
        w = '0;
        w[9:0]   = ghr[9:0];
        w[19:10] = idx[9:0];
        w[20]    = tk;
        return w;
    endfunction

    // One cycle of stimulus; the model advances history eagerly on acceptance.
    task automatic step(input bit req, input logic [31:0] pc, input bit busy,
                        input bit wbv, input bit wbt, input logic [2:0] wbidx,
                        input logic [63:0] wbst, input bit com, input bit comt,
                        input logic [63:0] comst);
        bit mis, acc, tk;
        int idx, ci;
        exp_t e;
        @(posedge clk); #1;
        pred_req_ = !req; pred_pc = pc; sb_busy = busy;
        wb_valid_ = !wbv; wb_taken = wbt; wb_st_idx = wbidx; wb_status = wbst;
        com_ = !com; com_taken = comt; com_status = comst;
        mis = wbv && (wbt != wbst[20]);
        #1;
        chk("pred_stall", pred_stall, busy || mis);
        chk("wb_flush_", wb_flush_, !mis);
        chk("sb_re_", sb_re_, !com);
        if (mis) begin
            if (prev_acc && q.size() > 0) void'(q.pop_back());
            m_ghr   = ((int'(wbst[9:0]) << 1) | int'(wbt)) & 'h3ff;
            m_alloc = (int'(wbidx) + 1) % 8;
        end
        acc = req && !busy && !mis;
        if (acc) begin
            idx = ((pc >> 2) ^ m_ghr) & 'h3ff;
            tk  = m_pht[idx] >= 2;
            e.taken = tk; e.st = m_alloc; e.wd = mk_status(m_ghr, idx, tk);
            q.push_back(e);
            m_ghr   = ((m_ghr << 1) | int'(tk)) & 'h3ff;
            m_alloc = (m_alloc + 1) % 8;
            recent.push_back(idx);
            if (recent.size() > 8) void'(recent.pop_front());
        end
        prev_acc = acc;
        if (com) begin
            ci = int'(comst[19:10]);
            if (comt) m_pht[ci] = (m_pht[ci] == 3) ? 3 : m_pht[ci] + 1;
            else      m_pht[ci] = (m_pht[ci] == 0) ? 0 : m_pht[ci] - 1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst pred_valid_", pred_valid_, 1);
        chk("rst sb_we_", sb_we_, 1);
        chk("rst pred_taken", pred_taken, 0);
        chk("rst pred_st_idx", pred_st_idx, 0);
        chk("rst sb_wd", sb_wd, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_ = 0; pred_req_ = 1; wb_valid_ = 1; com_ = 1; sb_busy = 0;
        model_reset();
        #1 chk_reset_outs();
        @(posedge clk); #1 reset_ = 1;
    endtask

    // Monitor: pops an expectation whenever the DUT issues a prediction.
    always @(negedge clk) begin
        exp_t e;
        if (reset_) begin
            chk("sb_we_ vs pred_valid_", sb_we_, pred_valid_);
            if (!pred_valid_) begin
                if (q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_issue: got st_idx %0d expected no issue", pred_st_idx);
                end else begin
                    e = q.pop_front();
                    chk("pred_taken", pred_taken, e.taken);
                    chk("pred_st_idx", pred_st_idx, e.st);
                    chk("sb_wd", sb_wd, e.wd);
                end
            end else begin
                chk("idle pred_taken", pred_taken, 0);
            end
        end
    end

    initial begin
        int pc, r;
        logic [63:0] ws, cs;
        model_reset();
        #2 chk_reset_outs();
        chk("rst wb_flush_", wb_flush_, 1);
        chk("rst sb_re_", sb_re_, 1);
        @(posedge clk); #1 reset_ = 1;

        // First prediction after reset.
        step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("d1 valid", pred_valid_, 0);
        chk("d1 taken", pred_taken, 0);
        chk("d1 st_idx", pred_st_idx, 0);
        chk("d1 pht_idx", sb_wd[19:10], 10'h040);
        chk("d1 ghr", sb_wd[9:0], 0);

        // Train entry 0x040 taken twice, then predict it.
        cs = mk_status(0, 'h40, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, cs);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, cs);
        step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("d2 taken", pred_taken, 1);
        // Saturation: third taken, one not-taken -> still taken (counter 2).
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, cs);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, cs);
        step(1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);  // ghr=1 -> index 0x040
        idle();
        chk("d2 sat taken", pred_taken, 1);

        // Four predictions then a mispredict on index 1 with a request in flight.
        for (int i = 0; i < 4; i++) step(1, 32'h300 + 4 * i, 0, 0, 0, 0, 0, 0, 0, 0);
        ws = mk_status('h155, 'h12, 0);
        step(1, 32'h200, 0, 1, 1, 3'd1, ws, 0, 0, 0);
        chk("d3 flush", wb_flush_, 0);
        idle();
        chk("d3 no issue", pred_valid_, 1);
        step(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("d3 st_idx", pred_st_idx, 2);
        chk("d3 ghr", sb_wd[9:0], 10'h2ab);

        // Busy blocks acceptance; release lets it through.
        step(1, 32'h400, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("d4 busy no issue", pred_valid_, 1);
        step(1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("d4 released issue", pred_valid_, 0);

        // Randomized traffic with a mid-run reset.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            pc = ($urandom_range(0, 3) == 0) ? int'($urandom) : ($urandom_range(0, 63) << 2);
            ws = {$urandom, $urandom};
            r  = (recent.size() > 0 && $urandom_range(0, 3) != 0)
                 ? recent[$urandom_range(0, recent.size() - 1)] : int'($urandom_range(0, 1023));
            cs = mk_status(int'($urandom), r, 1'($urandom));
            step($urandom_range(0, 9) < 7, pc, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, 1'($urandom), 3'($urandom), ws,
                 $urandom_range(0, 9) < 3, 1'($urandom_range(0, 2) != 0), cs);
        end
        idle();
        idle();
        chk("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/br_gshare_pred.md
# br_gshare_pred

Gshare conditional-branch direction predictor placed directly upstream of `br_status_buf`. On each conditional branch in fetch it indexes a 2-bit-counter pattern history table (PHT) with PC XOR global history. It returns the prediction one cycle later and allocates a status entry carrying the history snapshot.

It also:
- consumes `wb_status` at branch resolution, detects mispredictions and drives the buffer flush;
- restores the speculative global history register (GHR) on a flush;
- trains the PHT at commit from the retiring status entry.

## Interface
- `PC`, 32, PC width.
- `GHR_LEN`, 10, global history length in bits.
- `PHT_DEPTH`, 1024, number of 2-bit counters in the PHT.
- `SB_DEPTH`, `` `PredMaxDepth ``, number of status-buffer entries.
- `STATUS`, 64, status-word width. Must equal the `DATA` parameter of `br_status_buf`.
- Derived: `PHT_ADDR = $clog2(PHT_DEPTH)`, `SB_ADDR = $clog2(SB_DEPTH)`.

Ports (reset `reset_`, asynchronous, active-low; clock `clk`):
- `clk` in 1 — clock.
- `reset_` in 1 — asynchronous active-low reset.
- `pred_req_` in 1 — conditional-branch prediction request, active low.
- `pred_pc` in PC — branch PC.
- `pred_stall` out 1 — request cannot be accepted this cycle.
- `pred_valid_` out 1 — prediction result valid, active low.
- `pred_taken` out 1 — predicted direction.
- `pred_st_idx` out SB_ADDR — status-buffer index allocated to this branch.
- `sb_we_` out 1 — status-buffer write enable, active low.
- `sb_wd` out STATUS — status word to write.
- `sb_busy` in 1 — status buffer cannot accept a write.
- `wb_valid_` in 1 — a branch resolves in writeback, active low.
- `wb_taken` in 1 — actual direction of the resolving branch.
- `wb_st_idx` in SB_ADDR — status index of the resolving branch.
- `wb_status` in STATUS — status word read from the buffer at `wb_st_idx`.
- `wb_flush_` out 1 — misprediction flush to the buffer, active low, combinational.
- `com_` in 1 — oldest branch commits, active low.
- `com_taken` in 1 — actual direction of the committing branch.
- `com_status` in STATUS — the buffer's `rd` output.
- `sb_re_` out 1 — status-buffer read/retire enable, equal to `com_`.

## Operation
- Status word layout, LSB first, zero-padded to STATUS bits:
  - `ghr` [GHR_LEN] — history *before* this branch.
  - `pht_idx` [PHT_ADDR].
  - `pred_taken` [1].
- PHT index = `pred_pc[PHT_ADDR+1:2]` XOR the GHR, with the GHR zero-extended or truncated to PHT_ADDR bits.
- PHT counters: 2-bit saturating. Predict taken when `counter[1]` is 1.
- A request is accepted when `pred_req_`=0 and `pred_stall`=0. `pred_stall` = `sb_busy`.
- Accept stage (cycle N): compute the index, read the PHT, and latch {GHR snapshot, index, direction} into a single stage register S1.
- Issue stage (cycle N+1), when S1 is valid:
  - assert `pred_valid_`=0 and `sb_we_`=0 with `sb_wd` built from S1;
  - drive `pred_st_idx` = the allocation pointer `alloc`;
  - update GHR ← {GHR[GHR_LEN-2:0], pred_taken};
  - update `alloc` ← (`alloc`+1) mod SB_DEPTH.
- Resolution: mispredict = !`wb_valid_` && (`wb_taken` != `wb_status.pred_taken`). `wb_flush_` = !mispredict.
- On a mispredict:
  - GHR ← {`wb_status.ghr`[GHR_LEN-2:0], `wb_taken`};
  - `alloc` ← (`wb_st_idx`+1) mod SB_DEPTH;
  - S1 is invalidated;
  - a request accepted the same cycle is discarded, so `pred_stall` is forced to 1;
  - the issue-stage outputs are suppressed that cycle (`sb_we_`=1, `pred_valid_`=1).
- Commit: when `com_`=0, counter[`com_status.pht_idx`] increments (saturating at 3) if `com_taken`, otherwise decrements (saturating at 0).
- Reset values:
  - all PHT counters 2'b01;
  - GHR 0, `alloc` 0, S1 invalid;
  - `pred_valid_`=1, `sb_we_`=1, `pred_taken`=0, `pred_st_idx`=0, `sb_wd`=0.
  - `wb_flush_` and `sb_re_` follow their inputs.

## Timing
- Prediction latency is 1 cycle: request at N gives the result and the buffer write at N+1.
- Throughput is 1 prediction per cycle.
- GHR and `alloc` update at the N+1 clock edge, so a back-to-back request at N+1 indexes with the updated history. This requires a same-cycle forward of S1's direction into the index path.
- A commit write and a prediction read to the same counter in the same cycle: the read returns the old value (no bypass).
- Mispredict and commit in the same cycle: both take effect.
- Mispredict at N+1 while S1 is valid: the S1 branch is younger than the mispredicted branch and is dropped; the restore wins.
- `alloc` wraps from SB_DEPTH-1 to 0.
- `sb_busy` asserted while S1 is valid: S1 still issues, because the buffer's busy flag reserves one slot of look-ahead.
- Reset asserted mid-operation: asynchronous clear of all state; any in-flight S1 is lost.

## Structure
- `branch.svh` gets:
  - the packed `br_status_t` struct (fields `ghr`, `pht_idx`, `pred_taken`);
  - the `` `PhtDepth `` and `` `GhrLen `` defines;
  - the counter reset constant 2'b01.
- One sub-module, `br_pht`: PHT_DEPTH × 2-bit flop array with one combinational read port, one saturating-update write port, and asynchronous reset to 2'b01.

## Test plan
- Reset, then `pred_pc`=0x0000_0100 → at N+1: `pred_taken`=0, `pred_st_idx`=0, `sb_wd.pht_idx`=0x040, `sb_wd.ghr`=0, GHR=0.
- Commit `pht_idx`=0x040 taken twice, then predict 0x100 with GHR=0 → `pred_taken`=1. A third commit taken leaves the counter saturated at 3.
- Issue 4 predictions, then resolve `wb_st_idx`=1 with an actual direction opposite to its `pred_taken` → `wb_flush_`=0 that cycle, next `pred_st_idx`=2, GHR = {snapshot[8:0], `wb_taken`}.
- Request in the same cycle as a mispredict → `pred_stall`=1, no `sb_we_` at the next cycle.
- SB_DEPTH=8, 9 sequential predictions with commits keeping the buffer non-full → `pred_st_idx` sequence 0..7,0.
- `sb_busy`=1 with `pred_req_`=0 → `pred_stall`=1, no S1 capture. Release `sb_busy` → the request is accepted.
